pipe_stage_buf: RTL and testbench



---
 rtl/pipe_pkg.sv | 15 +
 rtl/dff.sv | 20 ++
 rtl/sat_counter.sv | 22 ++
 rtl/pipe_stage_buf.sv | 157 +++++++++++++++
 tb/tb_pipe_stage_buf.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffer.
// Holds the buffer state encoding and the all-zero bubble (NOP) payload.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } bufState_t;

    // Widest bus the bubble constant covers; users slice the low bits they need.
    localparam int BUBBLE_MAX_W = 4096;
    localparam logic [BUBBLE_MAX_W-1:0] BUBBLE = '0;

endpackage : pipe_pkg

// File: rtl/dff.sv
// Codebase storage cell: W-bit register with write enable and async active-low reset to zero.
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wen,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (wen) begin
            q <= d;
        end
    end

endmodule : dff

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/pipe_stage_buf.sv
// Parametrised valid/ready pipeline buffer with optional skid entry, flush-to-bubble
// and a saturating downstream-stall counter.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | main entry invalid, nothing for downstream
// ST_ONE   | main entry valid, skid entry free
// ST_TWO   | main and skid valid, upstream held off (SKID=1)
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 2,
    parameter int SKID   = 1,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*NUM_CH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH*NUM_CH-1:0] out_data,
    input  logic                    flush,
    output logic [CNT_W-1:0]        stall_cnt,
    input  logic                    stall_clr
);

    localparam int BUS_W = WIDTH * NUM_CH;

    bufState_t        stateQ;
    bufState_t        stateD;
    logic             accept;
    logic             consume;
    logic             mainWen;
    logic             skidWen;
    logic [BUS_W-1:0] mainD;
    logic [BUS_W-1:0] mainQ;
    logic [BUS_W-1:0] skidD;
    logic [BUS_W-1:0] skidQ;
    logic             inReady;
    logic             outValid;

    assign outValid = (stateQ != ST_EMPTY);
    assign accept   = in_valid & inReady;
    assign consume  = outValid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= ST_EMPTY;
        end else begin
            stateQ <= stateD;
        end
    end

    // Flush overrides everything: squash both entries to the bubble and drop any accept.
    always_comb begin
        stateD  = stateQ;
        mainWen = 1'b0;
        mainD   = in_data;
        skidWen = 1'b0;
        skidD   = in_data;
        if (flush) begin
            stateD  = ST_EMPTY;
            mainWen = 1'b1;
            mainD   = BUBBLE[BUS_W-1:0];
            skidWen = 1'b1;
            skidD   = BUBBLE[BUS_W-1:0];
        end else begin
            case (stateQ)
                ST_EMPTY: begin
                    if (accept) begin
                        stateD  = ST_ONE;
                        mainWen = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        mainWen = 1'b1;
                    end else if (accept) begin
                        if (SKID != 0) begin
                            stateD  = ST_TWO;
                            skidWen = 1'b1;
                        end
                    end else if (consume) begin
                        stateD = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        stateD  = ST_ONE;
                        mainWen = 1'b1;
                        mainD   = skidQ;
                    end
                end
                default: begin
                    stateD = ST_EMPTY;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : gMain
        dff #(.W(WIDTH)) uMain (
            .clk   (clk),
            .rst_n (rst_n),
            .wen   (mainWen),
            .d     (mainD[k*WIDTH +: WIDTH]),
            .q     (mainQ[k*WIDTH +: WIDTH])
        );
    end

    if (SKID != 0) begin : gSkid
        // in_ready comes straight from a flop so out_ready never reaches it combinationally.
        logic readyQ;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                readyQ <= 1'b1;
            end else begin
                readyQ <= (stateD != ST_TWO);
            end
        end

        assign inReady = readyQ;

        for (genvar k = 0; k < NUM_CH; k++) begin : gSkidCh
            dff #(.W(WIDTH)) uSkid (
                .clk   (clk),
                .rst_n (rst_n),
                .wen   (skidWen),
                .d     (skidD[k*WIDTH +: WIDTH]),
                .q     (skidQ[k*WIDTH +: WIDTH])
            );
        end
    end else begin : gNoSkid
        logic unusedSkid;

        assign inReady    = ~outValid | out_ready;
        assign skidQ      = '0;
        assign unusedSkid = ^{skidD, skidWen};
    end

    sat_counter #(.CNT_W(CNT_W)) uStallCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (outValid & ~out_ready),
        .clr   (stall_clr),
        .cnt   (stall_cnt)
    );

    assign in_ready  = inReady;
    assign out_valid = outValid;
    assign out_data  = mainQ;

endmodule : pipe_stage_buf

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: skid, no-skid and 4-bit-counter instances share one stimulus.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inV;
    logic [31:0] inD;
    logic        oR;
    logic        fl;
    logic        clr;

    logic        rdy1, val1;
    logic [31:0] dat1;
    logic [7:0]  cnt1;
    logic        rdy0, val0;
    logic [31:0] dat0;
    logic [7:0]  cnt0;
    logic        rdyC, valC;
    logic [31:0] datC;
    logic [3:0]  cntC;

    int vecCnt  = 0;
    int missCnt = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(16), .NUM_CH(2), .SKID(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inV), .in_ready(rdy1), .in_data(inD),
        .out_valid(val1), .out_ready(oR), .out_data(dat1), .flush(fl),
        .stall_cnt(cnt1), .stall_clr(clr)
    );

    pipe_stage_buf #(.WIDTH(16), .NUM_CH(2), .SKID(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(inV), .in_ready(rdy0), .in_data(inD),
        .out_valid(val0), .out_ready(oR), .out_data(dat0), .flush(fl),
        .stall_cnt(cnt0), .stall_clr(clr)
    );

    pipe_stage_buf #(.WIDTH(16), .NUM_CH(2), .SKID(1), .CNT_W(4)) dutC (
        .clk(clk), .rst_n(rst_n), .in_valid(inV), .in_ready(rdyC), .in_data(inD),
        .out_valid(valC), .out_ready(oR), .out_data(datC), .flush(fl),
        .stall_cnt(cntC), .stall_clr(clr)
    );

    typedef struct {
        logic        inV;
        logic [31:0] inD;
        logic        oR;
        logic        fl;
        logic        clr;
        logic        eRdy1;
        logic        eVal1;
        logic [31:0] eDat1;
        logic [7:0]  eCnt1;
        logic        eRdy0;
        logic        eVal0;
        logic [31:0] eDat0;
        logic [7:0]  eCnt0;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    task automatic checkPack(input string name, input logic [41:0] act, input logic [41:0] exp);
        vecCnt++;
        if (act !== exp) begin
            missCnt++;
            $display("FAIL %s: {rdy,val,data,cnt} got %h, want %h", name, act, exp);
        end
    endtask

    task automatic checkW(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCnt++;
        if (act !== exp) begin
            missCnt++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r,
                         input logic f, input logic c);
        inV = v;
        inD = d;
        oR  = r;
        fl  = f;
        clr = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // inV, inD, oR, fl, clr | skid: rdy, val, data, cnt | no-skid: rdy, val, data, cnt
        vecs[0]  = '{1'b1, 32'h0001_0002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0001_0002, 8'd0, 1'b1, 1'b1, 32'h0001_0002, 8'd0};
        vecs[1]  = '{1'b1, 32'h0003_0004, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0003_0004, 8'd0, 1'b1, 1'b1, 32'h0003_0004, 8'd0};
        vecs[2]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0003_0004, 8'd0, 1'b1, 1'b0, 32'h0003_0004, 8'd0};
        vecs[3]  = '{1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_1111, 8'd0, 1'b0, 1'b1, 32'h1111_1111, 8'd0};
        vecs[4]  = '{1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 8'd1, 1'b0, 1'b1, 32'h1111_1111, 8'd1};
        vecs[5]  = '{1'b1, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 8'd2, 1'b0, 1'b1, 32'h1111_1111, 8'd2};
        vecs[6]  = '{1'b1, 32'h3333_3333, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2222_2222, 8'd2, 1'b1, 1'b1, 32'h3333_3333, 8'd2};
        vecs[7]  = '{1'b1, 32'h3333_3333, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3333_3333, 8'd2, 1'b1, 1'b1, 32'h3333_3333, 8'd2};
        vecs[8]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3333_3333, 8'd2, 1'b1, 1'b0, 32'h3333_3333, 8'd2};
        vecs[9]  = '{1'b1, 32'h4444_4444, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4444_4444, 8'd2, 1'b0, 1'b1, 32'h4444_4444, 8'd2};
        vecs[10] = '{1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4444_4444, 8'd3, 1'b0, 1'b1, 32'h4444_4444, 8'd3};
        vecs[11] = '{1'b1, 32'h6666_6666, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 8'd4, 1'b1, 1'b0, 32'h0000_0000, 8'd4};
        vecs[12] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 8'd4, 1'b1, 1'b0, 32'h0000_0000, 8'd4};
        vecs[13] = '{1'b1, 32'h7777_7777, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7777_7777, 8'd4, 1'b0, 1'b1, 32'h7777_7777, 8'd4};
        vecs[14] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h7777_7777, 8'd0, 1'b1, 1'b0, 32'h7777_7777, 8'd0};

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #12;
        checkPack("reset skid1", {rdy1, val1, dat1, cnt1}, {1'b1, 1'b0, 32'h0, 8'd0});
        checkPack("reset skid0", {rdy0, val0, dat0, cnt0}, {1'b1, 1'b0, 32'h0, 8'd0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].inV, vecs[i].inD, vecs[i].oR, vecs[i].fl, vecs[i].clr);
            step();
            checkPack($sformatf("vec%0d skid1", i), {rdy1, val1, dat1, cnt1},
                      {vecs[i].eRdy1, vecs[i].eVal1, vecs[i].eDat1, vecs[i].eCnt1});
            checkPack($sformatf("vec%0d skid0", i), {rdy0, val0, dat0, cnt0},
                      {vecs[i].eRdy0, vecs[i].eVal0, vecs[i].eDat0, vecs[i].eCnt0});
        end

        // Stall counter saturation on the 4-bit instance, 8-bit one keeps counting.
        drive(1'b1, 32'h9999_9999, 1'b0, 1'b0, 1'b0);
        step();
        checkW("stall load data", dat1, 32'h9999_9999);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step();
            checkW($sformatf("stall cnt4 step%0d", k), {28'h0, cntC}, (k > 15) ? 32'd15 : 32'(k));
        end
        checkW("stall cnt8 after 20", {24'h0, cnt1}, 32'd20);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        checkW("stall clr cnt4", {28'h0, cntC}, 32'd0);
        checkW("stall clr cnt8", {24'h0, cnt1}, 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        checkW("stall restart cnt4", {28'h0, cntC}, 32'd1);

        // Fill to TWO, then drop reset between edges.
        drive(1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b0);
        step();
        checkPack("into TWO skid1", {rdy1, val1, dat1, cnt1}, {1'b0, 1'b1, 32'h9999_9999, 8'd2});
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkPack("async rst skid1", {rdy1, val1, dat1, cnt1}, {1'b1, 1'b0, 32'h0, 8'd0});
        checkPack("async rst skid0", {rdy0, val0, dat0, cnt0}, {1'b1, 1'b0, 32'h0, 8'd0});
        checkPack("async rst cnt4", {rdyC, valC, datC, 4'h0, cntC}, {1'b1, 1'b0, 32'h0, 8'd0});
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 32'hBBBB_BBBB, 1'b1, 1'b0, 1'b0);
        step();
        checkPack("post rst accept", {rdy1, val1, dat1, cnt1}, {1'b1, 1'b1, 32'hBBBB_BBBB, 8'd0});
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        checkPack("post rst drain", {rdy1, val1, dat1, cnt1}, {1'b1, 1'b0, 32'hBBBB_BBBB, 8'd0});

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule : tb_pipe_stage_buf
